// File: rtl/regfile_seq_pkg.sv
// Shared encodings for the register-file command sequencer.
package regfile_seq_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    typedef enum logic [1:0] {
        OP_MOVI = 2'b00,
        OP_ADD  = 2'b01,
        OP_AND  = 2'b10,
        OP_MVN  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        RDA,
        RDB,
        EXEC,
        WB
    } state_e;

endpackage

// File: rtl/alu16.sv
// Combinational ALU for the sequencer: result plus Z/N/V status.
module alu16 #(
    parameter int W = regfile_seq_pkg::DATA_W
) (
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         z,
    output logic         n,
    output logic         v
);
    import regfile_seq_pkg::*;

    always_comb begin
        result = '0;
        v      = 1'b0;
        unique case (op)
            OP_ADD: begin
                result = a + b;
                v      = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]);
            end
            OP_AND:  result = a & b;
            OP_MVN:  result = ~b;
            default: result = '0;
        endcase
        z = (result == '0);
        n = result[W-1];
    end

endmodule

// File: rtl/regfile.sv
// 8x16 register file: one combinational read port, one write port.
module regfile #(
    parameter int DATA_W = regfile_seq_pkg::DATA_W,
    parameter int ADDR_W = regfile_seq_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              write,
    input  logic [ADDR_W-1:0] writenum,
    input  logic [ADDR_W-1:0] readnum,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // No reset: contents survive a sequencer reset.
    always_ff @(posedge clk) begin
        if (write) mem[writenum] <= data_in;
    end

    assign data_out = mem[readnum];

endmodule

// File: rtl/regfile_sequencer.sv
// Sequences one register-to-register command at a time through the
// register file's single read port, then writes the result back.
module regfile_sequencer #(
    parameter int DATA_W = regfile_seq_pkg::DATA_W,
    parameter int ADDR_W = regfile_seq_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rn,
    input  logic [ADDR_W-1:0] cmd_rm,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [ADDR_W-1:0] readnum,
    input  logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] writenum,
    output logic              write,
    output logic [DATA_W-1:0] data_in,
    output logic              done,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_v
);
    import regfile_seq_pkg::*;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [ADDR_W-1:0] rm_q, rm_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] c_q, c_d;
    logic [ADDR_W-1:0] readnum_q, readnum_d;
    logic [ADDR_W-1:0] writenum_q, writenum_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic              write_q, write_d;
    logic              done_q, done_d;
    logic              z_q, z_d, n_q, n_d, v_q, v_d;

    logic [DATA_W-1:0] alu_res;
    logic              alu_z, alu_n, alu_v;

    alu16 #(.W(DATA_W)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_res),
        .z      (alu_z),
        .n      (alu_n),
        .v      (alu_v)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_d       = rd_q;
        rm_d       = rm_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        readnum_d  = readnum_q;
        writenum_d = writenum_q;
        data_in_d  = data_in_q;
        write_d    = 1'b0;
        done_d     = 1'b0;
        z_d        = z_q;
        n_d        = n_q;
        v_d        = v_q;
        // Port outputs are registered, so each is loaded on the edge
        // that enters the state where it must be valid.
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d = cmd_op;
                    rd_d = cmd_rd;
                    rm_d = cmd_rm;
                    unique case (cmd_op)
                        OP_MOVI: begin
                            state_d    = WB;
                            write_d    = 1'b1;
                            writenum_d = cmd_rd;
                            data_in_d  = cmd_imm;
                        end
                        OP_MVN: begin
                            state_d   = RDB;
                            readnum_d = cmd_rm;
                        end
                        default: begin
                            state_d   = RDA;
                            readnum_d = cmd_rn;
                        end
                    endcase
                end
            end
            RDA: begin
                a_d       = data_out;
                readnum_d = rm_q;
                state_d   = RDB;
            end
            RDB: begin
                b_d     = data_out;
                state_d = EXEC;
            end
            EXEC: begin
                c_d        = alu_res;
                z_d        = alu_z;
                n_d        = alu_n;
                v_d        = alu_v;
                write_d    = 1'b1;
                writenum_d = rd_q;
                data_in_d  = alu_res;
                state_d    = WB;
            end
            WB: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            rm_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            readnum_q  <= '0;
            writenum_q <= '0;
            data_in_q  <= '0;
            write_q    <= 1'b0;
            done_q     <= 1'b0;
            z_q        <= 1'b0;
            n_q        <= 1'b0;
            v_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rm_q       <= rm_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            readnum_q  <= readnum_d;
            writenum_q <= writenum_d;
            data_in_q  <= data_in_d;
            write_q    <= write_d;
            done_q     <= done_d;
            z_q        <= z_d;
            n_q        <= n_d;
            v_q        <= v_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign readnum   = readnum_q;
    assign writenum  = writenum_q;
    assign data_in   = data_in_q;
    assign write     = write_q;
    assign done      = done_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
    assign flag_v    = v_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench: sequencer driving a real register file end to end.
module tb_regfile_sequencer;
    import regfile_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_rd, cmd_rn, cmd_rm;
    logic [15:0] cmd_imm;
    logic [2:0]  readnum, writenum;
    logic [15:0] data_out, data_in;
    logic        write, done;
    logic        flag_z, flag_n, flag_v;

    int n_checks = 0;
    int n_fail   = 0;

    int          wr_cnt, wr_k, done_k, rdy_k;
    logic [2:0]  wr_num;
    logic [15:0] wr_data;
    logic [2:0]  rn_at [16];
    logic        rdy_at [16];

    always #5 clk = ~clk;

    regfile_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rn    (cmd_rn),
        .cmd_rm    (cmd_rm),
        .cmd_imm   (cmd_imm),
        .readnum   (readnum),
        .data_out  (data_out),
        .writenum  (writenum),
        .write     (write),
        .data_in   (data_in),
        .done      (done),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_v    (flag_v)
    );

    regfile u_rf (
        .clk      (clk),
        .write    (write),
        .writenum (writenum),
        .readnum  (readnum),
        .data_in  (data_in),
        .data_out (data_out)
    );

    // Present a command and return 1 ns after the accepting edge E0.
    task automatic send(input logic [1:0] op, input logic [2:0] rd,
                        input logic [2:0] rn, input logic [2:0] rm,
                        input logic [15:0] imm, input bit hold);
        int t = 0;
        cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_imm = imm;
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 20) begin
            @(posedge clk); #1; t++;
        end
        if (!cmd_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: cmd_ready=%b, required 1", cmd_ready);
        end
        @(posedge clk); #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Sample k is taken 1 ns after edge Ek (k=0 is just after accept).
    task automatic trace(input int n, input int drop_k);
        wr_cnt = 0; wr_k = -1; done_k = -1; rdy_k = -1;
        wr_num = '0; wr_data = '0;
        for (int k = 0; k < n; k++) begin
            rn_at[k]  = readnum;
            rdy_at[k] = cmd_ready;
            if (write) begin
                if (wr_cnt == 0) begin
                    wr_k = k; wr_num = writenum; wr_data = data_in;
                end
                wr_cnt++;
            end
            if (done && done_k < 0) done_k = k;
            if (cmd_ready && rdy_k < 0) rdy_k = k;
            if (k == drop_k) cmd_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic movi(input logic [2:0] rd, input logic [15:0] imm);
        send(OP_MOVI, rd, 3'd0, 3'd0, imm, 1'b0);
        trace(2, -1);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; cmd_valid = 1'b0;
        cmd_op = '0; cmd_rd = '0; cmd_rn = '0; cmd_rm = '0; cmd_imm = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, want 1", cmd_ready); end
        n_checks++; if (write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b, want 0", write); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, want 0", done); end
        n_checks++; if (readnum !== 3'd0) begin n_fail++; $display("FAIL reset_readnum: got %0d, want 0", readnum); end
        n_checks++; if (writenum !== 3'd0) begin n_fail++; $display("FAIL reset_writenum: got %0d, want 0", writenum); end
        n_checks++; if (data_in !== 16'h0000) begin n_fail++; $display("FAIL reset_data_in: got %h, want 0000", data_in); end
        n_checks++; if ({flag_z, flag_n, flag_v} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b, want 000", {flag_z, flag_n, flag_v}); end
    endtask

    task automatic test_movi;
        send(OP_MOVI, 3'd3, 3'd0, 3'd0, 16'h1234, 1'b0);
        trace(4, -1);
        n_checks++; if (wr_cnt != 1) begin n_fail++; $display("FAIL movi_write_cycles: got %0d, want 1", wr_cnt); end
        n_checks++; if (wr_k != 0) begin n_fail++; $display("FAIL movi_write_time: got %0d, want 0", wr_k); end
        n_checks++; if (wr_num !== 3'd3) begin n_fail++; $display("FAIL movi_writenum: got %0d, want 3", wr_num); end
        n_checks++; if (wr_data !== 16'h1234) begin n_fail++; $display("FAIL movi_data_in: got %h, want 1234", wr_data); end
        n_checks++; if (done_k != 1) begin n_fail++; $display("FAIL movi_done_time: got %0d, want 1", done_k); end
        n_checks++; if (u_rf.mem[3] !== 16'h1234) begin n_fail++; $display("FAIL movi_r3: got %h, want 1234", u_rf.mem[3]); end
        n_checks++; if ({flag_z, flag_n, flag_v} !== 3'b000) begin n_fail++; $display("FAIL movi_flags: got %b, want 000", {flag_z, flag_n, flag_v}); end
    endtask

    task automatic test_add_overflow;
        movi(3'd1, 16'h7FFF);
        movi(3'd2, 16'h0001);
        send(OP_ADD, 3'd0, 3'd1, 3'd2, 16'h0000, 1'b0);
        trace(6, -1);
        n_checks++; if (rn_at[0] !== 3'd1) begin n_fail++; $display("FAIL add_readnum_a: got %0d, want 1", rn_at[0]); end
        n_checks++; if (rn_at[1] !== 3'd2) begin n_fail++; $display("FAIL add_readnum_b: got %0d, want 2", rn_at[1]); end
        n_checks++; if (rn_at[5] !== 3'd2) begin n_fail++; $display("FAIL add_readnum_hold: got %0d, want 2", rn_at[5]); end
        n_checks++; if (wr_k != 3) begin n_fail++; $display("FAIL add_write_time: got %0d, want 3", wr_k); end
        n_checks++; if (done_k != 4) begin n_fail++; $display("FAIL add_done_time: got %0d, want 4", done_k); end
        n_checks++; if (u_rf.mem[0] !== 16'h8000) begin n_fail++; $display("FAIL add_r0: got %h, want 8000", u_rf.mem[0]); end
        n_checks++; if ({flag_z, flag_n, flag_v} !== 3'b011) begin n_fail++; $display("FAIL add_flags: got %b, want 011", {flag_z, flag_n, flag_v}); end
    endtask

    task automatic test_and_zero;
        movi(3'd4, 16'hF0F0);
        movi(3'd5, 16'h0F0F);
        n_checks++; if ({flag_z, flag_n, flag_v} !== 3'b011) begin n_fail++; $display("FAIL movi_keeps_flags: got %b, want 011", {flag_z, flag_n, flag_v}); end
        send(OP_AND, 3'd6, 3'd4, 3'd5, 16'h0000, 1'b0);
        trace(6, -1);
        n_checks++; if (u_rf.mem[6] !== 16'h0000) begin n_fail++; $display("FAIL and_r6: got %h, want 0000", u_rf.mem[6]); end
        n_checks++; if ({flag_z, flag_n, flag_v} !== 3'b100) begin n_fail++; $display("FAIL and_flags: got %b, want 100", {flag_z, flag_n, flag_v}); end
        n_checks++; if (done_k != 4) begin n_fail++; $display("FAIL and_done_time: got %0d, want 4", done_k); end
    endtask

    task automatic test_back_to_back;
        send(OP_MVN, 3'd7, 3'd0, 3'd1, 16'h0000, 1'b1);
        cmd_op = OP_ADD; cmd_rd = 3'd1; cmd_rn = 3'd1; cmd_rm = 3'd1;
        trace(10, 4);
        n_checks++; if (rn_at[0] !== 3'd1) begin n_fail++; $display("FAIL mvn_readnum: got %0d, want 1", rn_at[0]); end
        n_checks++; if (wr_k != 2) begin n_fail++; $display("FAIL mvn_write_time: got %0d, want 2", wr_k); end
        n_checks++; if (wr_data !== 16'h8000) begin n_fail++; $display("FAIL mvn_data_in: got %h, want 8000", wr_data); end
        n_checks++; if (done_k != 3) begin n_fail++; $display("FAIL mvn_done_time: got %0d, want 3", done_k); end
        n_checks++; if (rdy_k != 3) begin n_fail++; $display("FAIL bp_first_ready: got %0d, want 3", rdy_k); end
        n_checks++; if (rdy_at[4] !== 1'b0) begin n_fail++; $display("FAIL bp_accept_edge: ready=%b, want 0", rdy_at[4]); end
        n_checks++; if (wr_cnt != 2) begin n_fail++; $display("FAIL bp_write_count: got %0d, want 2", wr_cnt); end
        n_checks++; if (u_rf.mem[7] !== 16'h8000) begin n_fail++; $display("FAIL mvn_r7: got %h, want 8000", u_rf.mem[7]); end
        n_checks++; if (u_rf.mem[1] !== 16'hFFFE) begin n_fail++; $display("FAIL rbw_r1: got %h, want fffe", u_rf.mem[1]); end
        n_checks++; if ({flag_z, flag_n, flag_v} !== 3'b011) begin n_fail++; $display("FAIL rbw_flags: got %b, want 011", {flag_z, flag_n, flag_v}); end
    endtask

    task automatic test_reset_mid;
        send(OP_ADD, 3'd2, 3'd1, 3'd1, 16'h0000, 1'b0);
        trace(2, -1);
        reset_n = 1'b0;
        #1;
        n_checks++; if (write !== 1'b0) begin n_fail++; $display("FAIL mid_write_drop: got %b, want 0", write); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b, want 1", cmd_ready); end
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        trace(4, -1);
        n_checks++; if (wr_cnt != 0) begin n_fail++; $display("FAIL mid_no_write: got %0d, want 0", wr_cnt); end
        n_checks++; if (u_rf.mem[2] !== 16'h0001) begin n_fail++; $display("FAIL mid_r2: got %h, want 0001", u_rf.mem[2]); end
        n_checks++; if ({flag_z, flag_n, flag_v} !== 3'b000) begin n_fail++; $display("FAIL mid_flags: got %b, want 000", {flag_z, flag_n, flag_v}); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_after: got %b, want 1", cmd_ready); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_movi();
        test_add_overflow();
        test_and_zero();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Command sequencer that drives the single-read, single-write 8×16 register file port from the initiator side. It accepts one register-to-register command at a time over a valid/ready handshake. It reads the source operands over successive cycles through the file's single read port, computes the result, and writes it back to the destination register. It sits between the instruction decoder and the register file and replaces ad-hoc testbench driving of `readnum`/`writenum`/`write`.

## Interface
Parameters:
- `DATA_W`, 16, register and data width.
- `ADDR_W`, 3, register-number width (8 registers).

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept; high only in IDLE.
- `cmd_op`  in  2  00 MOVI, 01 ADD, 10 AND, 11 MVN.
- `cmd_rd`, `cmd_rn`, `cmd_rm`  in  ADDR_W each  destination and sources.
- `cmd_imm`  in  DATA_W  immediate for MOVI.
- `readnum`  out  ADDR_W  to register file read select.
- `data_out`  in  DATA_W  combinational read data from register file.
- `writenum`  out  ADDR_W  to register file write select.
- `write`  out  1  register file write enable.
- `data_in`  out  DATA_W  register file write data.
- `done`  out  1  one-cycle pulse after write-back edge.
- `flag_z`, `flag_n`, `flag_v`  out  1 each  status of last ALU command.

## Operation
- **States:** IDLE, RDA, RDB, EXEC, WB.
- **Accept:** a command is accepted on a posedge with IDLE & `cmd_valid`. At that edge, `op`, `rd`, `rn`, `rm` and `imm` are captured into internal registers. Later input changes are ignored.
- **Transitions from IDLE on accept:**
  - ADD/AND go to RDA.
  - MVN goes to RDB; `rn` is unused.
  - MOVI goes to WB.
- **RDA:** `readnum = rn`; `data_out` latched into A. Next state RDB.
- **RDB:** `readnum = rm`; `data_out` latched into B. Next state EXEC.
- **EXEC:** the result is latched into C:
  - ADD: A+B mod 2^16.
  - AND: A&B.
  - MVN: ~B.
- **Flags:** updated in EXEC only. MOVI leaves flags unchanged.
  - `flag_z` = (result == 0).
  - `flag_n` = result[15].
  - `flag_v` is the signed overflow of ADD (A[15]==B[15] && result[15]!=A[15]). It is 0 for AND/MVN.
- **WB:**
  - `write = 1`, `writenum = rd`.
  - `data_in` = C, or the captured `imm` for MOVI.
  - Next state IDLE; `done` is registered high for the following cycle.
- **Outputs outside the active states:**
  - `readnum` holds its last value outside RDA/RDB.
  - `write` is 0 in every state except WB.
- **Read-before-write:** `rd` may equal `rn` and/or `rm`. Sources are always read before the write edge, so the old value is used.
- **Back-pressure:** `cmd_valid` held while busy is not accepted. There is no queue, and the command is not lost as long as the source holds it.
- **Reset values** (asserting `reset_n` low forces all of these asynchronously):
  - state IDLE, so `cmd_ready` = 1.
  - A, B, C = 0; `readnum`, `writenum` = 0; `data_in` = 0.
  - `write` = 0, `done` = 0, all flags = 0.
- **Reset mid-command:** the in-flight command is dropped with no write. Register file contents are untouched, since the register file has no reset.

## Timing
- Accept edge E0. Each state occupies exactly one cycle.
- **Write edge** (where the register file captures `data_in`):
  - MOVI: E1.
  - MVN: E3.
  - ADD/AND: E4.
- **`done`** is high in the cycle after the write edge, which is IDLE. `cmd_ready` is also high in that cycle, so the next command can be accepted at the end of the `done` cycle.
- **Issue interval:** ADD every 5 cycles, MVN every 4, MOVI every 2.
- **Read-port timing:** `readnum` is registered and changes at the edge entering RDA/RDB. `data_out` must settle within that cycle, which the combinational read guarantees.
- **Flag timing:** flags are valid from the edge leaving EXEC and hold until the next EXEC.

## Structure
- Package `regfile_seq_pkg`:
  - op encodings `OP_MOVI`/`OP_ADD`/`OP_AND`/`OP_MVN`.
  - state enum `IDLE`/`RDA`/`RDB`/`EXEC`/`WB`.
  - `DATA_W`/`ADDR_W` defaults.
- One combinational sub-module, `alu16`, computing result, Z, N and V from op, A and B. The FSM and the capture registers stay in `regfile_sequencer`.
- The bench instantiates `regfile_sequencer` together with `regfile` to check write-back end to end.

## Test plan
- **MOVI:** reset, then MOVI rd=3 imm=0x1234.
  - `write` is high for exactly one cycle, with `writenum` = 3 and `data_in` = 0x1234.
  - `done` fires 2 cycles after E0; R3 reads 0x1234.
- **ADD with overflow:** R1=0x7FFF, R2=0x0001, then ADD rd=0 rn=1 rm=2.
  - R0 = 0x8000; Z=0, N=1, V=1.
  - `done` fires 5 cycles after E0; `readnum` sequence is 1 then 2.
- **AND to zero:** R4=0xF0F0, R5=0x0F0F, then AND rd=6 rn=4 rm=5.
  - R6 = 0x0000; Z=1, N=0, V=0.
- **MVN and back-pressure:** MVN rd=7 rm=1 with R1=0x7FFF, with `cmd_valid` held high for a second command (ADD rd=1 rn=1 rm=1).
  - R7 = 0x8000.
  - The second command is accepted only in the `done` cycle.
  - R1 = 0xFFFE, confirming the old value was read before the write.
- **Reset mid-command:** pulse `reset_n` low during EXEC of ADD rd=2.
  - `write` drops immediately and no write occurs; R2 is unchanged.
  - Flags read 0 and `cmd_ready` = 1 after release.
